// File: rtl/musa_ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: states, opcodes,
// PC source and ALU operation selects, operand mux codes and the wait limit.
package musa_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_EXEC   = 4'd2,
      ST_MEM    = 4'd3,
      ST_WB     = 4'd4,
      ST_BRANCH = 4'd5,
      ST_JUMP   = 4'd6,
      ST_STACK  = 4'd7
   } state_e;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_PUSH = 6'b111000;
   localparam logic [5:0] OP_POP  = 6'b111001;

   localparam logic [2:0] PC_HOLD   = 3'd0;
   localparam logic [2:0] PC_SEQ    = 3'd1;
   localparam logic [2:0] PC_BRANCH = 3'd2;
   localparam logic [2:0] PC_JUMP   = 3'd3;

   localparam logic [2:0] ALU_NOP  = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_FUNC = 3'd3;

   localparam logic [1:0] SEL_PC   = 2'd0;
   localparam logic [1:0] SEL_RD1  = 2'd1;
   localparam logic [1:0] SEL_OUT  = 2'd2;
   localparam logic [1:0] SEL_FOUR = 2'd3;

   localparam logic [3:0] WAIT_LIMIT = 4'd15;

endpackage

// File: rtl/multicycle_sequencer_wait_timer.sv
// Memory wait watchdog: counts stalled access cycles and flags expiry when
// the count sits at the limit while the access is still stalled.
module wait_timer
   import musa_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == WAIT_LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control sequencer: Moore decode of state and latched opcode
// into datapath strobes, with a memory-wait watchdog.
//   state  | meaning
//   FETCH  | read instruction, PC+4; wait for mem_ready
//   DECODE | latch opcode, compute branch target, dispatch
//   EXEC   | ALU op for R-type / address or immediate add
//   MEM    | LW read or SW write until mem_ready
//   WB     | register write-back, retire
//   BRANCH | compare operands, conditional PC write, retire
//   JUMP   | PC <- jump target, retire
//   STACK  | PUSH write or POP read until mem_ready
module multicycle_sequencer
   import musa_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       push,
   output logic       pop,
   output logic [2:0] pc_src,
   output logic [2:0] alu_op,
   output logic [1:0] data_a_select,
   output logic [1:0] data_b_select,
   output logic       retire,
   output logic       illegal,
   output logic       mem_err,
   output logic [3:0] state
);

   state_e     state_q, state_d;
   logic [5:0] op_q, op_d;
   logic       mem_access, timer_en, timer_clr, expire;

   // Only these states ever drive mem_read or mem_write.
   assign mem_access = (state_q == ST_FETCH) || (state_q == ST_MEM) || (state_q == ST_STACK);
   assign timer_en   = mem_access && !mem_ready;
   assign timer_clr  = (state_d != state_q) || expire;

   wait_timer u_wait_timer (
      .clk      (clk),
      .rst_n    (rst),
      .clr_i    (timer_clr),
      .en_i     (timer_en),
      .expire_o (expire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_FETCH;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      push          = 1'b0;
      pop           = 1'b0;
      retire        = 1'b0;
      illegal       = 1'b0;
      mem_err       = 1'b0;
      pc_src        = PC_HOLD;
      alu_op        = ALU_NOP;
      data_a_select = SEL_PC;
      data_b_select = SEL_PC;

      unique case (state_q)
         ST_FETCH: begin
            mem_read      = 1'b1;
            data_b_select = SEL_FOUR;
            alu_op        = ALU_ADD;
            pc_src        = PC_SEQ;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = ST_DECODE;
            end
         end
         ST_DECODE: begin
            op_d          = opcode;
            data_b_select = SEL_OUT;
            alu_op        = ALU_ADD;
            case (opcode)
               OP_R, OP_LW, OP_SW, OP_ADDI: state_d = ST_EXEC;
               OP_BEQ:                      state_d = ST_BRANCH;
               OP_J:                        state_d = ST_JUMP;
               OP_PUSH, OP_POP:             state_d = ST_STACK;
               default: begin
                  illegal = 1'b1;
                  state_d = ST_FETCH;
               end
            endcase
         end
         ST_EXEC: begin
            data_a_select = SEL_RD1;
            if (op_q == OP_R) begin
               alu_op        = ALU_FUNC;
               data_b_select = SEL_RD1;
               state_d       = ST_WB;
            end else begin
               alu_op        = ALU_ADD;
               data_b_select = SEL_OUT;
               state_d       = (op_q == OP_ADDI) ? ST_WB : ST_MEM;
            end
         end
         ST_MEM: begin
            mem_read  = (op_q == OP_LW);
            mem_write = (op_q == OP_SW);
            if (mem_ready) begin
               if (op_q == OP_LW) begin
                  state_d = ST_WB;
               end else begin
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (op_q == OP_LW) || (op_q == OP_POP);
            reg_dst    = (op_q == OP_R);
            retire     = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_BRANCH: begin
            alu_op        = ALU_SUB;
            data_a_select = SEL_RD1;
            data_b_select = SEL_RD1;
            pc_src        = PC_BRANCH;
            pc_write      = zero;
            retire        = 1'b1;
            state_d       = ST_FETCH;
         end
         ST_JUMP: begin
            pc_src   = PC_JUMP;
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = ST_FETCH;
         end
         ST_STACK: begin
            if (op_q == OP_POP) begin
               pop      = 1'b1;
               mem_read = 1'b1;
               if (mem_ready) state_d = ST_WB;
            end else begin
               push      = 1'b1;
               mem_write = 1'b1;
               if (mem_ready) begin
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end
            end
         end
         default: state_d = ST_FETCH;
      endcase

      // Watchdog expiry abandons the instruction: no strobes, no retire.
      if (expire) begin
         state_d    = ST_FETCH;
         mem_err    = 1'b1;
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         mem_to_reg = 1'b0;
         reg_dst    = 1'b0;
         push       = 1'b0;
         pop        = 1'b0;
         retire     = 1'b0;
      end

      // Reset must silence outputs immediately, not at the next edge.
      if (!rst) begin
         pc_write      = 1'b0;
         ir_write      = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         reg_write     = 1'b0;
         mem_to_reg    = 1'b0;
         reg_dst       = 1'b0;
         push          = 1'b0;
         pop           = 1'b0;
         retire        = 1'b0;
         illegal       = 1'b0;
         mem_err       = 1'b0;
         pc_src        = PC_HOLD;
         alu_op        = ALU_NOP;
         data_a_select = SEL_PC;
         data_b_select = SEL_PC;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: per-instruction expected output traces are built up front
// and compared against the sequencer every cycle.
module tb_multicycle_sequencer;
   import musa_ctrl_pkg::*;

   typedef struct packed {
      logic       pc_write, ir_write, mem_read, mem_write, reg_write;
      logic       mem_to_reg, reg_dst, push, pop;
      logic [2:0] pc_src;
      logic [2:0] alu_op;
      logic [1:0] a_sel;
      logic [1:0] b_sel;
      logic       retire, illegal, mem_err;
      logic [3:0] state;
   } outs_t;

   typedef struct packed {
      logic       rst;
      logic [5:0] op;
      logic       zero;
      logic       rdy;
      outs_t      exp;
   } cyc_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [5:0] opcode = '0;
   logic zero = 1'b0;
   logic mem_ready = 1'b0;

   logic pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, reg_dst, push, pop;
   logic [2:0] pc_src, alu_op;
   logic [1:0] a_sel, b_sel;
   logic retire, illegal, mem_err;
   logic [3:0] state;
   outs_t act;

   cyc_t plan[$];
   cyc_t cur;
   int   cur_idx;
   logic active = 1'b0;
   int   checks = 0, passed = 0;
   int   n_retire = 0, n_illegal = 0, n_err = 0, n_push = 0, n_pop = 0, n_rw = 0;

   multicycle_sequencer dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .push(push), .pop(pop),
      .pc_src(pc_src), .alu_op(alu_op), .data_a_select(a_sel), .data_b_select(b_sel),
      .retire(retire), .illegal(illegal), .mem_err(mem_err), .state(state)
   );

   assign act = {pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, reg_dst, push, pop,
                 pc_src, alu_op, a_sel, b_sel, retire, illegal, mem_err, state};

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a === e) passed++;
      else $display("FAIL %s: got %h, expected %h", nm, a, e);
   endtask

   // ---- expected-trace builders ----
   function automatic outs_t blank(input logic [3:0] st);
      outs_t o;
      o = '0;
      o.state = st;
      return o;
   endfunction

   task automatic put(input logic r, input logic [5:0] op, input logic z, input logic rdy, input outs_t e);
      cyc_t c;
      c.rst = r; c.op = op; c.zero = z; c.rdy = rdy; c.exp = e;
      plan.push_back(c);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) put(1'b0, 6'd0, 1'b0, 1'b0, '0);
   endtask

   task automatic do_fetch(input logic [5:0] op, input int waits);
      outs_t e;
      e = blank(4'd0);
      e.mem_read = 1'b1; e.b_sel = 2'd3; e.alu_op = ALU_ADD; e.pc_src = PC_SEQ;
      for (int i = 0; i < waits; i++) put(1'b1, op, 1'b0, 1'b0, e);
      e.ir_write = 1'b1; e.pc_write = 1'b1;
      put(1'b1, op, 1'b0, 1'b1, e);
   endtask

   task automatic do_decode(input logic [5:0] op);
      outs_t e;
      e = blank(4'd1);
      e.b_sel = 2'd2; e.alu_op = ALU_ADD;
      e.illegal = !(op inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW, OP_PUSH, OP_POP});
      put(1'b1, op, 1'b0, 1'b0, e);
   endtask

   task automatic do_exec_add(input logic [5:0] op);
      outs_t e;
      e = blank(4'd2);
      e.a_sel = 2'd1; e.b_sel = 2'd2; e.alu_op = ALU_ADD;
      put(1'b1, op, 1'b0, 1'b0, e);
   endtask

   // A memory access: `waits` stalled cycles, then either completion or watchdog expiry.
   task automatic do_access(input logic [5:0] op, input outs_t e, input int waits,
                            input bit timeout, input bit fin_retire);
      outs_t t;
      for (int i = 0; i < waits; i++) put(1'b1, op, 1'b0, 1'b0, e);
      if (timeout) begin
         t = blank(e.state);
         t.mem_err = 1'b1;
         put(1'b1, op, 1'b0, 1'b0, t);
      end else begin
         e.retire = fin_retire;
         put(1'b1, op, 1'b0, 1'b1, e);
      end
   endtask

   task automatic do_wb(input logic [5:0] op);
      outs_t e;
      e = blank(4'd4);
      e.reg_write = 1'b1; e.retire = 1'b1;
      e.mem_to_reg = (op == OP_LW) || (op == OP_POP);
      e.reg_dst = (op == OP_R);
      put(1'b1, op, 1'b0, 1'b0, e);
   endtask

   task automatic ins_r(input int fw);
      outs_t e;
      do_fetch(OP_R, fw); do_decode(OP_R);
      e = blank(4'd2);
      e.a_sel = 2'd1; e.b_sel = 2'd1; e.alu_op = ALU_FUNC;
      put(1'b1, OP_R, 1'b0, 1'b0, e);
      do_wb(OP_R);
   endtask

   task automatic ins_lw(input int fw, input int mw);
      outs_t e;
      do_fetch(OP_LW, fw); do_decode(OP_LW); do_exec_add(OP_LW);
      e = blank(4'd3); e.mem_read = 1'b1;
      do_access(OP_LW, e, mw, 1'b0, 1'b0);
      do_wb(OP_LW);
   endtask

   task automatic ins_sw(input int mw, input bit timeout);
      outs_t e;
      do_fetch(OP_SW, 0); do_decode(OP_SW); do_exec_add(OP_SW);
      e = blank(4'd3); e.mem_write = 1'b1;
      do_access(OP_SW, e, mw, timeout, 1'b1);
   endtask

   task automatic ins_addi();
      do_fetch(OP_ADDI, 0); do_decode(OP_ADDI); do_exec_add(OP_ADDI); do_wb(OP_ADDI);
   endtask

   task automatic ins_beq(input logic z);
      outs_t e;
      do_fetch(OP_BEQ, 0); do_decode(OP_BEQ);
      e = blank(4'd5);
      e.alu_op = ALU_SUB; e.a_sel = 2'd1; e.b_sel = 2'd1; e.pc_src = PC_BRANCH;
      e.pc_write = z; e.retire = 1'b1;
      put(1'b1, OP_BEQ, z, 1'b0, e);
   endtask

   task automatic ins_j();
      outs_t e;
      do_fetch(OP_J, 0); do_decode(OP_J);
      e = blank(4'd6);
      e.pc_src = PC_JUMP; e.pc_write = 1'b1; e.retire = 1'b1;
      put(1'b1, OP_J, 1'b0, 1'b0, e);
   endtask

   task automatic ins_push(input int sw);
      outs_t e;
      do_fetch(OP_PUSH, 0); do_decode(OP_PUSH);
      e = blank(4'd7); e.push = 1'b1; e.mem_write = 1'b1;
      do_access(OP_PUSH, e, sw, 1'b0, 1'b1);
   endtask

   task automatic ins_pop(input int sw);
      outs_t e;
      do_fetch(OP_POP, 0); do_decode(OP_POP);
      e = blank(4'd7); e.pop = 1'b1; e.mem_read = 1'b1;
      do_access(OP_POP, e, sw, 1'b0, 1'b0);
      do_wb(OP_POP);
   endtask

   task automatic ins_bad(input logic [5:0] op);
      do_fetch(op, 1); do_decode(op);
   endtask

   // ---- per-cycle compare ----
   always @(negedge clk) begin
      if (active) begin
         check($sformatf("cycle%0d_outputs", cur_idx), 32'(act), 32'(cur.exp));
         check($sformatf("cycle%0d_push_pop_excl", cur_idx), 32'(push & pop), 32'd0);
         check($sformatf("cycle%0d_rw_mw_excl", cur_idx), 32'(reg_write & mem_write), 32'd0);
         if (retire)    n_retire++;
         if (illegal)   n_illegal++;
         if (mem_err)   n_err++;
         if (push)      n_push++;
         if (pop)       n_pop++;
         if (reg_write) n_rw++;
      end
   end

   // ---- stimulus ----
   initial begin
      outs_t e;
      do_reset(2);
      ins_r(0);
      ins_lw(1, 3);
      ins_beq(1'b1);
      ins_beq(1'b0);
      ins_addi();
      ins_j();
      ins_sw(15, 1'b1);
      ins_sw(15, 1'b0);
      ins_bad(6'b111111);
      ins_push(2);
      ins_pop(1);
      do_fetch(OP_LW, 0); do_decode(OP_LW); do_exec_add(OP_LW);
      e = blank(4'd3); e.mem_read = 1'b1;
      put(1'b1, OP_LW, 1'b0, 1'b0, e);
      put(1'b1, OP_LW, 1'b0, 1'b0, e);
      do_reset(2);
      ins_r(2);

      foreach (plan[i]) begin
         @(posedge clk);
         #1;
         rst       = plan[i].rst;
         opcode    = plan[i].op;
         zero      = plan[i].zero;
         mem_ready = plan[i].rdy;
         cur       = plan[i];
         cur_idx   = i;
         active    = 1'b1;
      end
      @(negedge clk);
      #1;
      active = 1'b0;

      check("retire_total",    32'(n_retire),  32'd10);
      check("illegal_total",   32'(n_illegal), 32'd1);
      check("mem_err_total",   32'(n_err),     32'd1);
      check("push_cycles",     32'(n_push),    32'd3);
      check("pop_cycles",      32'(n_pop),     32'd2);
      check("reg_write_total", 32'(n_rw),      32'd5);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have ports clk (input, 1, rising-edge clock) and rst (input, 1, reset); one clock, reset asynchronous and active-low.
REQ-002 SHALL have opcode (input, 6): instruction[31:26] from the IR, valid from DECODE onward.
REQ-003 SHALL have zero (input, 1): ALU zero flag, sampled in BRANCH.
REQ-004 SHALL have mem_ready (input, 1): memory access completes this cycle.
REQ-005 SHALL have pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, reg_dst, push, pop (output, 1 each): datapath strobes.
REQ-006 SHALL have pc_src (output, 3) and alu_op (output, 3): encodings from the shared package.
REQ-007 SHALL have data_a_select, data_b_select (output, 2 each): ALU operand muxes (0=PC/regA-off, 1=readData1, 2=outputWord, 3=const 4).
REQ-008 SHALL have retire (output, 1; one-cycle pulse per completed instruction), illegal (output, 1; pulse), mem_err (output, 1; pulse), state (output, 4; current state).

Function
REQ-009 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, STACK; all outputs SHALL be Moore decodes of state and latched opcode, except strobes gated by mem_ready where stated.
REQ-010 FETCH: mem_read=1, data_a_select=0, data_b_select=3, alu_op=ADD; on mem_ready SHALL pulse ir_write and pc_write (pc_src=SEQ) and go DECODE, else hold.
REQ-011 DECODE: SHALL latch opcode into op_q; data_b_select=2, alu_op=ADD (branch target); next R/LW/SW/ADDI->EXEC, BEQ->BRANCH, J->JUMP, PUSH/POP->STACK; any other opcode SHALL pulse illegal and go FETCH.
REQ-012 EXEC: R-type alu_op=FUNC, data_b_select=1, ->WB; LW/SW/ADDI alu_op=ADD, data_b_select=2; LW/SW->MEM, ADDI->WB.
REQ-013 MEM: LW mem_read=1, SW mem_write=1, held until mem_ready; then LW->WB, SW->FETCH with retire pulse.
REQ-014 WB: reg_write=1 for one cycle; mem_to_reg=1 for LW/POP; reg_dst=1 for R-type only; retire pulse; ->FETCH.
REQ-015 BRANCH: alu_op=SUB, data_b_select=1, pc_src=BRANCH, pc_write=zero; retire; ->FETCH.
REQ-016 JUMP: pc_src=JUMP, pc_write=1; retire; ->FETCH.
REQ-017 STACK: PUSH asserts push and mem_write until mem_ready, then retire, ->FETCH; POP asserts pop and mem_read until mem_ready, then ->WB.
REQ-018 Wait counter (4 bits) SHALL clear on every state entry and count cycles with mem_read|mem_write asserted and mem_ready low; on reaching 15 SHALL pulse mem_err, suppress all strobes that cycle, and go FETCH without retire.
REQ-019 mem_ready arriving on the same cycle as counter=15 SHALL win: access completes normally, no mem_err.
REQ-020 push and pop SHALL never both be 1; reg_write and mem_write SHALL never both be 1.

Reset
REQ-021 rst low SHALL asynchronously force state=FETCH, op_q=0, wait counter=0, and all outputs 0 (including in mid-access states); first FETCH strobes appear the first cycle after rst rises.

Structure
REQ-022 Package musa_ctrl_pkg SHALL hold state enum, opcode constants (R=000000, J=000010, BEQ=000100, ADDI=001000, LW=100011, SW=101011, PUSH=111000, POP=111001), pc_src and alu_op encodings, and WAIT_LIMIT=15.
REQ-023 One sub-module wait_timer (4-bit counter with clear/enable/expire) SHALL be instantiated; next-state and output decode stay in this module.

Verification
REQ-024 R-type, mem_ready=1 in FETCH -> states FETCH,DECODE,EXEC,WB; reg_write+reg_dst in cycle 4; retire once.
REQ-025 LW with mem_ready low 3 cycles in MEM -> mem_read held 4 cycles, then WB with mem_to_reg=1; 5+3=8 cycles total plus FETCH waits.
REQ-026 BEQ with zero=1 then zero=0 -> pc_write=1 (pc_src=BRANCH) first, pc_write=0 second; both retire.
REQ-027 SW with mem_ready never asserted -> mem_err pulse after 15 wait cycles, no retire, back to FETCH; mem_ready on cycle 15 -> no mem_err.
REQ-028 Opcode 111111 -> illegal pulse in DECODE, FETCH next, no retire; PUSH -> push+mem_write until mem_ready, pop never high.
REQ-029 rst driven low mid-MEM (asynchronously, between edges) -> all outputs 0 immediately, state=FETCH; resumes fetch after release.
